// File: rtl/cmd_sched.sv
// rtl/cmd_sched.sv - SD command scheduler: one software slot, one auto CMD12 slot, issue FSM
// Optional response timeout enabled by defining SDHCI_CMD_SCHED_TIMEOUT_EN.
module cmd_sched #(
  parameter int unsigned RspTimeout = 64,
  parameter logic [31:0] Cmd12Arg   = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sd_clk_en_i,
  input  logic        sw_req_i,
  input  logic [5:0]  sw_index_i,
  input  logic [31:0] sw_arg_i,
  input  logic        sw_rsp_present_i,
  input  logic        acmd12_req_i,
  output logic        issue_valid_o,
  input  logic        issue_ready_i,
  output logic [5:0]  issue_index_o,
  output logic [31:0] issue_arg_o,
  output logic        issue_rsp_o,
  output logic        issue_auto_o,
  input  logic        cmd_done_i,
  input  logic        rsp_done_i,
  output logic        cmd_inhibit_o,
  output logic        cmd_complete_o,
  output logic        auto_cmd12_complete_o,
  output logic        rsp_timeout_o,
  output logic        sw_drop_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT_CMD = 3'd2;
  localparam logic [2:0] S_WAIT_RSP = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [5:0] Cmd12Index = 6'd12;

  logic [2:0]  r_state;

  // Pending software slot with its latched payload
  logic        r_sw_pend;
  logic [5:0]  r_sw_index;
  logic [31:0] r_sw_arg;
  logic        r_sw_rsp;

  // Pending auto CMD12 slot (payload is fixed)
  logic        r_auto_pend;

  // Payload of the command currently owned by the FSM, frozen at selection
  logic        r_cur_auto;
  logic [5:0]  r_issue_index;
  logic [31:0] r_issue_arg;
  logic        r_issue_rsp;

  logic        r_sw_drop;

  logic        w_inhibit;
  logic        w_sw_accept;
  logic        w_auto_busy;
  logic        w_auto_accept;
  logic        w_handshake;
  logic        w_to_hit;
  logic        w_timed_out;

  // Software writes are locked out while anything is in progress or queued
  assign w_inhibit     = (r_state != S_IDLE) || r_sw_pend;
  assign w_sw_accept   = sw_req_i && !w_inhibit;

  // An auto request is redundant while one is queued or still being executed
  assign w_auto_busy   = r_auto_pend || ((r_state != S_IDLE) && r_cur_auto);
  assign w_auto_accept = acmd12_req_i && !w_auto_busy;

  assign w_handshake   = (r_state == S_ISSUE) && issue_ready_i;

`ifdef SDHCI_CMD_SCHED_TIMEOUT_EN
  localparam int CntW = $clog2(RspTimeout + 1);

  logic [CntW-1:0] r_rsp_cnt;
  logic [CntW-1:0] w_rsp_cnt_nxt;
  logic            r_to_pulse;
  logic            r_timed_out;

  assign w_rsp_cnt_nxt = r_rsp_cnt + 1'b1;

  // A response that lands on the same pulse as the limit still counts as received
  assign w_to_hit = (r_state == S_WAIT_RSP) && !rsp_done_i && sd_clk_en_i &&
                    (w_rsp_cnt_nxt == CntW'(RspTimeout));

  // Count SD clock pulses while waiting; held at zero elsewhere so each wait starts fresh
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_cnt <= '0;
    end else if (r_state != S_WAIT_RSP) begin
      r_rsp_cnt <= '0;
    end else if (sd_clk_en_i) begin
      r_rsp_cnt <= w_rsp_cnt_nxt;
    end
  end

  // Timeout pulse, and a flag that suppresses the completion pulse in DONE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_to_pulse  <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      r_to_pulse <= w_to_hit;
      if (w_to_hit) begin
        r_timed_out <= 1'b1;
      end else if (r_state == S_DONE) begin
        r_timed_out <= 1'b0;
      end
    end
  end

  assign w_timed_out   = r_timed_out;
  assign rsp_timeout_o = r_to_pulse;
`else
  logic w_unused_cfg;

  assign w_unused_cfg  = sd_clk_en_i & (RspTimeout > 0);
  assign w_to_hit      = 1'b0;
  assign w_timed_out   = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  // Software slot: set by an accepted write, cleared when its command is handed off
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sw_pend  <= 1'b0;
      r_sw_index <= '0;
      r_sw_arg   <= '0;
      r_sw_rsp   <= 1'b0;
    end else if (w_handshake && !r_cur_auto) begin
      r_sw_pend <= 1'b0;
    end else if (w_sw_accept) begin
      r_sw_pend  <= 1'b1;
      r_sw_index <= sw_index_i;
      r_sw_arg   <= sw_arg_i;
      r_sw_rsp   <= sw_rsp_present_i;
    end
  end

  // Auto slot: set by an accepted request pulse, cleared when its command is handed off
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_auto_pend <= 1'b0;
    end else if (w_handshake && r_cur_auto) begin
      r_auto_pend <= 1'b0;
    end else if (w_auto_accept) begin
      r_auto_pend <= 1'b1;
    end
  end

  // Rejected software write is reported one cycle later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sw_drop <= 1'b0;
    end else begin
      r_sw_drop <= sw_req_i && w_inhibit;
    end
  end

  // Command sequencing; payload is captured on leaving IDLE so it stays stable through ISSUE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= S_IDLE;
      r_cur_auto    <= 1'b0;
      r_issue_index <= '0;
      r_issue_arg   <= '0;
      r_issue_rsp   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_auto_pend || r_sw_pend) begin
            r_state    <= S_ISSUE;
            r_cur_auto <= r_auto_pend;
            if (r_auto_pend) begin
              r_issue_index <= Cmd12Index;
              r_issue_arg   <= Cmd12Arg;
              r_issue_rsp   <= 1'b1;
            end else begin
              r_issue_index <= r_sw_index;
              r_issue_arg   <= r_sw_arg;
              r_issue_rsp   <= r_sw_rsp;
            end
          end
        end
        S_ISSUE: begin
          if (issue_ready_i) begin
            r_state <= S_WAIT_CMD;
          end
        end
        S_WAIT_CMD: begin
          // cmd_done_i wins; a simultaneous rsp_done_i is dropped here
          if (cmd_done_i) begin
            r_state <= r_issue_rsp ? S_WAIT_RSP : S_DONE;
          end
        end
        S_WAIT_RSP: begin
          if (rsp_done_i || w_to_hit) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign issue_valid_o         = (r_state == S_ISSUE);
  assign issue_index_o         = r_issue_index;
  assign issue_arg_o           = r_issue_arg;
  assign issue_rsp_o           = r_issue_rsp;
  assign issue_auto_o          = r_cur_auto;
  assign cmd_inhibit_o         = w_inhibit;
  assign cmd_complete_o        = (r_state == S_DONE) && !r_cur_auto && !w_timed_out;
  assign auto_cmd12_complete_o = (r_state == S_DONE) && r_cur_auto && !w_timed_out;
  assign sw_drop_o             = r_sw_drop;

endmodule

// File: tb/tb_cmd_sched.sv
// tb/tb_cmd_sched.sv - self-checking bench for cmd_sched
module tb_cmd_sched;

  localparam int unsigned RSP_TO    = 4;
  localparam logic [31:0] CMD12_ARG = 32'hC0DE_0012;

  localparam int ST_OFFER  = 0;
  localparam int ST_SENT   = 1;
  localparam int ST_RSP    = 2;
  localparam int ST_RETIRE = 3;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        sd_clk_en_i;
  logic        sw_req_i;
  logic [5:0]  sw_index_i;
  logic [31:0] sw_arg_i;
  logic        sw_rsp_present_i;
  logic        acmd12_req_i;
  logic        issue_valid_o;
  logic        issue_ready_i;
  logic [5:0]  issue_index_o;
  logic [31:0] issue_arg_o;
  logic        issue_rsp_o;
  logic        issue_auto_o;
  logic        cmd_done_i;
  logic        rsp_done_i;
  logic        cmd_inhibit_o;
  logic        cmd_complete_o;
  logic        auto_cmd12_complete_o;
  logic        rsp_timeout_o;
  logic        sw_drop_o;

  int n_checks = 0;
  int n_fail   = 0;

  cmd_sched #(.RspTimeout(RSP_TO), .Cmd12Arg(CMD12_ARG)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .sd_clk_en_i(sd_clk_en_i),
    .sw_req_i(sw_req_i), .sw_index_i(sw_index_i), .sw_arg_i(sw_arg_i),
    .sw_rsp_present_i(sw_rsp_present_i), .acmd12_req_i(acmd12_req_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_index_o(issue_index_o), .issue_arg_o(issue_arg_o),
    .issue_rsp_o(issue_rsp_o), .issue_auto_o(issue_auto_o),
    .cmd_done_i(cmd_done_i), .rsp_done_i(rsp_done_i),
    .cmd_inhibit_o(cmd_inhibit_o), .cmd_complete_o(cmd_complete_o),
    .auto_cmd12_complete_o(auto_cmd12_complete_o),
    .rsp_timeout_o(rsp_timeout_o), .sw_drop_o(sw_drop_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "bench did not terminate");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [45:0] all_outs();
    return {issue_valid_o, issue_index_o, issue_arg_o, issue_rsp_o, issue_auto_o,
            cmd_inhibit_o, cmd_complete_o, auto_cmd12_complete_o, rsp_timeout_o, sw_drop_o};
  endfunction

  task automatic clear_inputs();
    sd_clk_en_i = 0; sw_req_i = 0; sw_index_i = 0; sw_arg_i = 0; sw_rsp_present_i = 0;
    acmd12_req_i = 0; issue_ready_i = 0; cmd_done_i = 0; rsp_done_i = 0;
  endtask

  // ---------------- table-driven single-command vectors ----------------
  typedef struct {
    bit          is_auto;
    logic [5:0]  idx;
    logic [31:0] arg;
    bit          rsp;
    int          delay;    // ISSUE cycles with ready low before the handshake cycle
    bit          both;     // raise rsp_done together with cmd_done
    logic [5:0]  e_idx;
    logic [31:0] e_arg;
    bit          e_rsp;
    bit          e_auto;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    sw_index_i = v.idx; sw_arg_i = v.arg; sw_rsp_present_i = v.rsp;
    if (v.is_auto) acmd12_req_i = 1; else sw_req_i = 1;
    tick();
    sw_req_i = 0; acmd12_req_i = 0;
    chk({tag, ".inhibit_pending"}, cmd_inhibit_o, !v.is_auto);
    chk({tag, ".valid_early"}, issue_valid_o, 0);
    tick();
    chk({tag, ".valid"}, issue_valid_o, 1);
    chk({tag, ".payload"}, {issue_index_o, issue_arg_o, issue_rsp_o, issue_auto_o},
        {v.e_idx, v.e_arg, v.e_rsp, v.e_auto});
    for (int i = 1; i < v.delay; i++) begin
      tick();
      chk($sformatf("%s.hold%0d", tag, i),
          {issue_valid_o, issue_index_o, issue_arg_o, issue_rsp_o, issue_auto_o},
          {1'b1, v.e_idx, v.e_arg, v.e_rsp, v.e_auto});
    end
    issue_ready_i = 1;
    tick();
    issue_ready_i = 0;
    chk({tag, ".valid_after_hs"}, issue_valid_o, 0);
    rsp_done_i = 1;
    tick();
    rsp_done_i = 0;
    chk({tag, ".stray_rsp"}, {cmd_complete_o, auto_cmd12_complete_o, cmd_inhibit_o}, 3'b001);
    cmd_done_i = 1; rsp_done_i = v.both;
    tick();
    cmd_done_i = 0; rsp_done_i = 0;
    if (v.e_rsp) begin
      chk({tag, ".wait_rsp"}, {cmd_complete_o, auto_cmd12_complete_o}, 2'b00);
      rsp_done_i = 1;
      tick();
      rsp_done_i = 0;
    end
    chk({tag, ".done_pulse"}, {cmd_complete_o, auto_cmd12_complete_o}, {!v.e_auto, v.e_auto});
    tick();
    chk({tag, ".idle"}, {cmd_complete_o, auto_cmd12_complete_o, cmd_inhibit_o, issue_valid_o}, 4'b0);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    bit          rsp;
    bit          au;
  } cmd_t;

  bit   m_sw_pend, m_auto_pend, m_active, m_drop, m_to, m_tout_flag;
  cmd_t m_sw, m_cur;
  int   m_stage;
`ifdef SDHCI_CMD_SCHED_TIMEOUT_EN
  int   m_cnt;
`endif

  task automatic model_reset();
    m_sw_pend = 0; m_auto_pend = 0; m_active = 0; m_drop = 0; m_to = 0; m_tout_flag = 0;
    m_stage = ST_OFFER;
    m_sw = '{6'd0, 32'd0, 1'b0, 1'b0};
    m_cur = m_sw;
`ifdef SDHCI_CMD_SCHED_TIMEOUT_EN
    m_cnt = 0;
`endif
  endtask

  task automatic model_step(input bit sw, input cmd_t req, input bit ac, input bit rdy,
                            input bit cd, input bit rd, input bit en);
    bit inh, sw_ok, ac_ok;
    inh   = m_active || m_sw_pend;
    sw_ok = sw && !inh;
    ac_ok = ac && !m_auto_pend && !(m_active && m_cur.au);
    m_drop = sw && inh;
    m_to   = 0;
    if (!m_active) begin
      if (m_auto_pend || m_sw_pend) begin
        m_active = 1; m_stage = ST_OFFER; m_tout_flag = 0;
        m_cur = m_auto_pend ? '{6'd12, CMD12_ARG, 1'b1, 1'b1} : m_sw;
      end
    end else begin
      case (m_stage)
        ST_OFFER: if (rdy) begin
          if (m_cur.au) m_auto_pend = 0; else m_sw_pend = 0;
          m_stage = ST_SENT;
        end
        ST_SENT: if (cd) begin
          m_stage = m_cur.rsp ? ST_RSP : ST_RETIRE;
`ifdef SDHCI_CMD_SCHED_TIMEOUT_EN
          m_cnt = 0;
`endif
        end
        ST_RSP: begin
          if (rd) m_stage = ST_RETIRE;
`ifdef SDHCI_CMD_SCHED_TIMEOUT_EN
          else if (en) begin
            m_cnt++;
            if (m_cnt == RSP_TO) begin
              m_to = 1; m_tout_flag = 1; m_stage = ST_RETIRE;
            end
          end
`endif
        end
        default: m_active = 0;
      endcase
    end
    if (sw_ok) begin
      m_sw_pend = 1; m_sw = req; m_sw.au = 0;
    end
    if (ac_ok) m_auto_pend = 1;
  endtask

  task automatic compare_model(input int cyc);
    bit offer, retire;
    offer  = m_active && (m_stage == ST_OFFER);
    retire = m_active && (m_stage == ST_RETIRE) && !m_tout_flag;
    chk($sformatf("rnd%0d.valid", cyc), issue_valid_o, offer);
    chk($sformatf("rnd%0d.inhibit", cyc), cmd_inhibit_o, m_active || m_sw_pend);
    chk($sformatf("rnd%0d.pulses", cyc),
        {cmd_complete_o, auto_cmd12_complete_o, rsp_timeout_o, sw_drop_o},
        {retire && !m_cur.au, retire && m_cur.au, m_to, m_drop});
    if (offer)
      chk($sformatf("rnd%0d.payload", cyc),
          {issue_index_o, issue_arg_o, issue_rsp_o, issue_auto_o},
          {m_cur.idx, m_cur.arg, m_cur.rsp, m_cur.au});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[5];
    vec_t v;
    int   nv;

    vecs[0] = '{1'b0, 6'd17, 32'h0000_0200, 1'b1, 0, 1'b0, 6'd17, 32'h0000_0200, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 6'd63, 32'hFFFF_FFFF, 1'b0, 2, 1'b1, 6'd63, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 6'd0,  32'h1234_5678, 1'b1, 5, 1'b1, 6'd0,  32'h1234_5678, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 6'd5,  32'h0000_DEAD, 1'b0, 3, 1'b1, 6'd12, CMD12_ARG,     1'b1, 1'b1};
    vecs[4] = '{1'b0, 6'd41, 32'hA5A5_5A5A, 1'b1, 1, 1'b1, 6'd41, 32'hA5A5_5A5A, 1'b1, 1'b0};

    clear_inputs();
    rst_ni = 0;
    tick();
    tick();
    chk("reset.outputs", all_outs(), 46'd0);
    rst_ni = 1;
    tick();
    chk("reset.released_idle", all_outs(), 46'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // simultaneous software and auto requests: auto first, software after auto completes
    sw_req_i = 1; sw_index_i = 6'd33; sw_arg_i = 32'h3300_0033; sw_rsp_present_i = 0;
    acmd12_req_i = 1;
    tick();
    sw_req_i = 0; acmd12_req_i = 0;
    chk("both.inhibit", cmd_inhibit_o, 1);
    tick();
    chk("both.first", {issue_valid_o, issue_index_o, issue_arg_o, issue_auto_o},
        {1'b1, 6'd12, CMD12_ARG, 1'b1});
    issue_ready_i = 1; tick(); issue_ready_i = 0;
    cmd_done_i = 1; tick(); cmd_done_i = 0;
    rsp_done_i = 1; tick(); rsp_done_i = 0;
    chk("both.auto_done", {auto_cmd12_complete_o, cmd_complete_o}, 2'b10);
    tick();
    chk("both.gap", {issue_valid_o, cmd_inhibit_o}, 2'b01);
    tick();
    chk("both.second", {issue_valid_o, issue_index_o, issue_arg_o, issue_rsp_o, issue_auto_o},
        {1'b1, 6'd33, 32'h3300_0033, 1'b0, 1'b0});
    issue_ready_i = 1; tick(); issue_ready_i = 0;
    cmd_done_i = 1; tick(); cmd_done_i = 0;
    chk("both.sw_done", {auto_cmd12_complete_o, cmd_complete_o}, 2'b01);
    tick();
    chk("both.idle", cmd_inhibit_o, 0);

    // second software write while inhibited is dropped
    sw_req_i = 1; sw_index_i = 6'd7; sw_arg_i = 32'h77; sw_rsp_present_i = 0;
    tick();
    sw_index_i = 6'd9; sw_arg_i = 32'h99;
    tick();
    sw_req_i = 0;
    chk("drop.pulse", sw_drop_o, 1);
    chk("drop.kept_first", {issue_valid_o, issue_index_o, issue_arg_o}, {1'b1, 6'd7, 32'h77});
    issue_ready_i = 1; tick(); issue_ready_i = 0;
    chk("drop.single_pulse", sw_drop_o, 0);
    cmd_done_i = 1; tick(); cmd_done_i = 0;
    chk("drop.done", cmd_complete_o, 1);
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      nv += int'(issue_valid_o);
    end
    chk("drop.no_second_issue", nv, 0);

    // response wait behaviour with SD clock enable pulses
    sw_req_i = 1; sw_index_i = 6'd8; sw_arg_i = 32'h8; sw_rsp_present_i = 1;
    tick(); sw_req_i = 0;
    tick();
    issue_ready_i = 1; tick(); issue_ready_i = 0;
    cmd_done_i = 1; sd_clk_en_i = 1; tick(); cmd_done_i = 0; sd_clk_en_i = 0;
`ifdef SDHCI_CMD_SCHED_TIMEOUT_EN
    for (int p = 1; p <= int'(RSP_TO); p++) begin
      sd_clk_en_i = 1; tick(); sd_clk_en_i = 0;
      if (p < int'(RSP_TO)) begin
        chk($sformatf("to.pulse%0d", p), {rsp_timeout_o, cmd_complete_o, cmd_inhibit_o}, 3'b001);
        tick();
        chk($sformatf("to.gap%0d", p), rsp_timeout_o, 0);
      end
    end
    chk("to.fire", {rsp_timeout_o, cmd_complete_o, cmd_inhibit_o}, 3'b101);
    tick();
    chk("to.idle", {rsp_timeout_o, cmd_complete_o, cmd_inhibit_o}, 3'b000);
`else
    for (int p = 0; p < 12; p++) begin
      sd_clk_en_i = (p % 2 == 0); tick();
    end
    sd_clk_en_i = 0;
    chk("nto.still_waiting", {rsp_timeout_o, cmd_complete_o, cmd_inhibit_o}, 3'b001);
    rsp_done_i = 1; tick(); rsp_done_i = 0;
    chk("nto.done", cmd_complete_o, 1);
    tick();
    chk("nto.idle", cmd_inhibit_o, 0);
`endif

    // reset asserted while waiting for a response
    sw_req_i = 1; sw_index_i = 6'd20; sw_arg_i = 32'h2020; sw_rsp_present_i = 1;
    tick(); sw_req_i = 0;
    tick();
    issue_ready_i = 1; tick(); issue_ready_i = 0;
    cmd_done_i = 1; tick(); cmd_done_i = 0;
    rst_ni = 0;
    #1;
    chk("rst.async", all_outs(), 46'd0);
    rsp_done_i = 1;
    tick();
    rsp_done_i = 0;
    chk("rst.held", all_outs(), 46'd0);
    rst_ni = 1;
    tick();
    chk("rst.no_pulse", all_outs(), 46'd0);
    v = '{1'b0, 6'd21, 32'h2121_0000, 1'b1, 0, 1'b0, 6'd21, 32'h2121_0000, 1'b1, 1'b0};
    run_vec(v, "rst.reissue");

    // randomized stimulus against the reference model
    clear_inputs();
    rst_ni = 0;
    tick();
    model_reset();
    rst_ni = 1;
    for (int c = 0; c < 600; c++) begin
      cmd_t r;
      bit sw, ac, rdy, cd, rd, en;
      compare_model(c);
      sw  = ($urandom_range(0, 4) == 0);
      ac  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 1) == 0);
      cd  = ($urandom_range(0, 2) == 0);
      rd  = ($urandom_range(0, 3) == 0);
      en  = ($urandom_range(0, 1) == 0);
      r.idx = 6'($urandom);
      r.arg = $urandom;
      r.rsp = 1'($urandom);
      r.au  = 1'b0;
      sw_req_i = sw; sw_index_i = r.idx; sw_arg_i = r.arg; sw_rsp_present_i = r.rsp;
      acmd12_req_i = ac; issue_ready_i = rdy; cmd_done_i = cd; rsp_done_i = rd; sd_clk_en_i = en;
      model_step(sw, r, ac, rdy, cd, rd, en);
      tick();
    end
    compare_model(600);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
